fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 SHALL have parameter PC_STEP, default 4, byte increment between sequential fetches.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port PC_write  input  1  hazard-unit PC enable; 0 = hold PC.
REQ-006 SHALL have port IF_ID_write  input  1  hazard-unit IF/ID enable; 0 = hold IF/ID contents.
REQ-007 SHALL have port branch_taken  input  1  resolved redirect, one-cycle pulse.
REQ-008 SHALL have port branch_target  input  32  redirect address, sampled when branch_taken=1.
REQ-009 SHALL have port imem_req  output  1  instruction fetch request.
REQ-010 SHALL have port imem_addr  output  32  fetch address.
REQ-011 SHALL have port imem_ready  input  1  fetch complete; imem_rdata valid this cycle.
REQ-012 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-013 SHALL have port IF_ID_pc  output  32  PC of the instruction held in IF/ID.
REQ-014 SHALL have port IF_ID_instr  output  32  instruction held in IF/ID.
REQ-015 SHALL have port IF_ID_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, DROP; one outstanding fetch maximum.
REQ-017 IDLE: imem_req=0; SHALL move to REQ on the first clock edge after reset release.
REQ-018 REQ: imem_req=1, imem_addr=PC; imem_addr SHALL stay stable until imem_ready=1.
REQ-019 REQ with imem_ready=1, PC_write=1, IF_ID_write=1, branch_taken=0: IF/ID <= {PC, imem_rdata, valid=1}; PC <= PC+PC_STEP (mod 2^32, wraps to 0); remain in REQ.
REQ-020 REQ with imem_ready=1 and (PC_write=0 or IF_ID_write=0): returned word SHALL be discarded, PC held, and the same address re-requested next cycle; IF/ID held when IF_ID_write=0.
REQ-021 REQ with imem_ready=0 and IF_ID_write=1: IF/ID SHALL load a bubble (IF_ID_valid=0; pc/instr don't-care but held).
REQ-022 IF_ID_write=0 SHALL hold IF_ID_pc, IF_ID_instr, IF_ID_valid unchanged, regardless of other inputs except branch_taken and reset.
REQ-023 branch_taken=1 SHALL override stalls: IF_ID_valid <= 0, PC <= branch_target.
REQ-024 branch_taken=1 in REQ with imem_ready=1, or in IDLE: next state REQ at branch_target.
REQ-025 branch_taken=1 in REQ with imem_ready=0: branch_target SHALL be captured in a redirect register, state -> DROP.
REQ-026 DROP: imem_req=1, imem_addr=old address held; on imem_ready=1 the word SHALL be discarded and state -> REQ with PC=redirect register; IF_ID_valid SHALL stay 0 throughout DROP.
REQ-027 A second branch_taken while in DROP SHALL overwrite the redirect register (latest target wins).
REQ-028 Priority SHALL be: reset > branch_taken > IF_ID_write/PC_write stall > imem wait.
REQ-029 Fetch latency SHALL be: imem_ready in cycle N -> IF_ID_valid=1 with that word visible after edge N.
REQ-030 All outputs SHALL be registered except imem_req and imem_addr, which decode from state/PC only (no input-to-output combinational path).

Reset
REQ-031 rst_n=0 SHALL asynchronously force state=IDLE, PC=RESET_PC, redirect register=0, IF_ID_pc=0, IF_ID_instr=0, IF_ID_valid=0, imem_req=0.
REQ-032 Reset asserted mid-fetch (REQ or DROP) SHALL abandon the request; the response is ignored and the first post-reset request is to RESET_PC.

Verification
REQ-033 Reset release, imem_ready always 1, rdata=addr^32'hA5A5A5A5 -> IF_ID sequence pc 0,4,8 with valid=1 from the 2nd edge after release.
REQ-034 imem_ready low 3 cycles at addr 8 -> imem_addr held at 8, IF_ID_valid=0 for 3 cycles, then pc=8 valid=1.
REQ-035 IF_ID_write=0, PC_write=0 for 2 cycles while pc=4 in IF/ID -> IF/ID unchanged, imem_addr stays 8, then resumes with pc=8.
REQ-036 branch_taken with target 32'h100 while fetch at 12 pending -> DROP, addr 12 held until ready, word dropped, next request 32'h100, no valid instruction from addr 12.
REQ-037 PC=32'hFFFF_FFFC fetch completes -> next imem_addr 32'h0000_0000.
REQ-038 rst_n pulsed low during DROP -> all outputs at reset values immediately, first request at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage with a single outstanding request to instruction
//   memory and an IF/ID pipeline register feeding decode.
//
//   Ports
//     clk            clock, all state updates on the rising edge
//     rst_n          asynchronous active-low reset
//     PC_write       hazard unit: 0 = hold PC
//     IF_ID_write    hazard unit: 0 = hold IF/ID contents
//     branch_taken   resolved redirect (one-cycle pulse)
//     branch_target  redirect address, sampled with branch_taken
//     imem_req       fetch request (decoded from state)
//     imem_addr      fetch address (the PC register)
//     imem_ready     fetch complete, imem_rdata valid this cycle
//     imem_rdata     fetched instruction word
//     IF_ID_pc       PC of the instruction held in IF/ID
//     IF_ID_instr    instruction held in IF/ID
//     IF_ID_valid    1 = real instruction, 0 = bubble
//
//   States: IDLE (after reset), REQ (fetching at PC), DROP (a redirect arrived
//   while a fetch was pending; that fetch completes and is thrown away, then
//   fetching restarts at the captured redirect target).
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        PC_write,
   input  logic        IF_ID_write,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IF_ID_pc,
   output logic [31:0] IF_ID_instr,
   output logic        IF_ID_valid
);

   localparam logic [31:0] PC_INC = 32'(PC_STEP);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t      state_r,       state_s;
   logic [31:0] pc_r,          pc_s;
   logic [31:0] redirect_r,    redirect_s;
   logic [31:0] ifid_pc_r,     ifid_pc_s;
   logic [31:0] ifid_instr_r,  ifid_instr_s;
   logic        ifid_valid_r,  ifid_valid_s;

   // Next-state and next-register computation; every register holds by default.
   always_comb begin
      state_s      = state_r;
      pc_s         = pc_r;
      redirect_s   = redirect_r;
      ifid_pc_s    = ifid_pc_r;
      ifid_instr_s = ifid_instr_r;
      ifid_valid_s = ifid_valid_r;

      case (state_r)
         IDLE: begin
            // Leave IDLE unconditionally on the first edge after reset.
            state_s = REQ;
            if (branch_taken) begin
               pc_s         = branch_target;
               ifid_valid_s = 1'b0;
            end else if (IF_ID_write) begin
               ifid_valid_s = 1'b0;
            end else begin
               ifid_valid_s = ifid_valid_r;
            end
         end

         REQ: begin
            if (branch_taken) begin
               // Redirect overrides any stall.
               ifid_valid_s = 1'b0;
               if (imem_ready) begin
                  pc_s = branch_target;
               end else begin
                  // Fetch still in flight: keep the address stable, finish it
                  // in DROP and restart from the captured target afterwards.
                  redirect_s = branch_target;
                  state_s    = DROP;
               end
            end else if (imem_ready && PC_write && IF_ID_write) begin
               ifid_pc_s    = pc_r;
               ifid_instr_s = imem_rdata;
               ifid_valid_s = 1'b1;
               pc_s         = pc_r + PC_INC;
            end else if (IF_ID_write) begin
               // No word accepted this cycle (waiting, or PC stalled): bubble.
               ifid_valid_s = 1'b0;
            end else begin
               ifid_valid_s = ifid_valid_r;
            end
         end

         DROP: begin
            ifid_valid_s = 1'b0;
            // Latest redirect wins, including one arriving with the response.
            if (branch_taken) begin
               redirect_s = branch_target;
            end else begin
               redirect_s = redirect_r;
            end
            if (imem_ready) begin
               state_s = REQ;
               if (branch_taken) begin
                  pc_s = branch_target;
               end else begin
                  pc_s = redirect_r;
               end
            end else begin
               state_s = DROP;
            end
         end

         default: begin
            state_s      = IDLE;
            pc_s         = RESET_PC;
            ifid_valid_s = 1'b0;
         end
      endcase
   end

   // State, PC, redirect and IF/ID registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         pc_r         <= RESET_PC;
         redirect_r   <= 32'h0000_0000;
         ifid_pc_r    <= 32'h0000_0000;
         ifid_instr_r <= 32'h0000_0000;
         ifid_valid_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         pc_r         <= pc_s;
         redirect_r   <= redirect_s;
         ifid_pc_r    <= ifid_pc_s;
         ifid_instr_r <= ifid_instr_s;
         ifid_valid_r <= ifid_valid_s;
      end
   end

   // Request decodes from state only; the address is the PC register, which
   // is not updated while a fetch is outstanding, so it stays stable.
   assign imem_req    = (state_r != IDLE);
   assign imem_addr   = pc_r;
   assign IF_ID_pc    = ifid_pc_r;
   assign IF_ID_instr = ifid_instr_r;
   assign IF_ID_valid = ifid_valid_r;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Randomized plus directed stimulus for fetch_stage. The driver applies
//   inputs on the falling edge, advances a behavioural model of the fetch
//   rules and pushes the expected post-edge outputs into a scoreboard queue.
//   A monitor pops one entry 1 time unit after each rising edge and compares.
//   Instruction memory returns addr ^ 32'hA5A5A5A5.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        PC_write, IF_ID_write, branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] IF_ID_pc, IF_ID_instr;
   logic        IF_ID_valid;

   fetch_stage #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .PC_write     (PC_write),
      .IF_ID_write  (IF_ID_write),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .IF_ID_pc     (IF_ID_pc),
      .IF_ID_instr  (IF_ID_instr),
      .IF_ID_valid  (IF_ID_valid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t sb_q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   // Reference model: where fetching stands and what IF/ID should hold.
   logic        m_started, m_drop, m_valid;
   logic [31:0] m_pc, m_redir, m_ipc, m_instr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_A5A5;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      PC_write      = 1'b1;
      IF_ID_write   = 1'b1;
      branch_taken  = 1'b0;
      branch_target = 32'h0000_0000;
      imem_ready    = 1'b0;
      imem_rdata    = 32'h0000_0000;
      #1;
      // Asynchronous: no clock edge has occurred since rst_n fell.
      check("rst_req",   {31'd0, imem_req},    32'd0);
      check("rst_addr",  imem_addr,            RST_PC);
      check("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
      check("rst_pc",    IF_ID_pc,             32'd0);
      check("rst_instr", IF_ID_instr,          32'd0);
      m_started = 1'b0;
      m_drop    = 1'b0;
      m_valid   = 1'b0;
      m_pc      = RST_PC;
      m_redir   = 32'd0;
      m_ipc     = 32'd0;
      m_instr   = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock cycle: drive inputs, advance the model, queue expectations.
   task automatic cycle(input logic pw, input logic iw, input logic bt,
                        input logic [31:0] bta, input logic rdy);
      exp_t e;
      PC_write      = pw;
      IF_ID_write   = iw;
      branch_taken  = bt;
      branch_target = bta;
      imem_ready    = rdy;
      imem_rdata    = rdy ? mem_word(imem_addr) : $urandom();

      if (!m_started) begin
         m_started = 1'b1;
         if (bt) begin
            m_pc = bta; m_valid = 1'b0;
         end else if (iw) begin
            m_valid = 1'b0;
         end
      end else if (m_drop) begin
         m_valid = 1'b0;
         if (bt) m_redir = bta;
         if (rdy) begin
            m_pc = m_redir; m_drop = 1'b0;
         end
      end else if (bt) begin
         m_valid = 1'b0;
         if (rdy) m_pc = bta;
         else begin
            m_redir = bta; m_drop = 1'b1;
         end
      end else if (rdy && pw && iw) begin
         m_valid = 1'b1;
         m_ipc   = m_pc;
         m_instr = mem_word(m_pc);
         m_pc    = m_pc + 32'd4;
      end else if (iw) begin
         m_valid = 1'b0;
      end

      e.req   = m_started;
      e.addr  = m_pc;
      e.valid = m_valid;
      e.pc    = m_ipc;
      e.instr = m_instr;
      sb_q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: compare DUT outputs shortly after each active edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("imem_req", {31'd0, imem_req}, {31'd0, e.req});
         if (e.req) check("imem_addr", imem_addr, e.addr);
         check("IF_ID_valid", {31'd0, IF_ID_valid}, {31'd0, e.valid});
         if (e.valid) begin
            check("IF_ID_pc",    IF_ID_pc,    e.pc);
            check("IF_ID_instr", IF_ID_instr, e.instr);
         end
      end
   end

   initial begin
      logic [31:0] tgt;
      rst_n = 1'b1;
      @(negedge clk);
      do_reset();

      // Straight-line fetch 0,4 then a 3-cycle wait at 8.
      repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
      repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
      // Hazard stall with ready high: word discarded, IF/ID and PC held.
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
      // Branch while fetch at 16 pending -> DROP, then restart at 0x100.
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
      repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
      repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
      // Wrap at the top of the address space.
      cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
      repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
      // Second redirect during DROP wins.
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b0);
      repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
      // Reset in the middle of DROP.
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_0400, 1'b0);
      do_reset();
      repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2))
                                              : ($urandom() & 32'hFFFF_FFFC);
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 9) == 0, tgt, $urandom_range(0, 9) < 6);
         end
      end

      repeat (2) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
